// File: rtl/core_savestate_pkg.sv
// Shared types for the core savestate engine: FSM states and request kinds.
package core_savestate_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_PAUSE,
      ST_SAVE_RD,
      ST_SAVE_WR,
      ST_LOAD_RA,
      ST_LOAD_RW,
      ST_LOAD_WR,
      ST_RESUME,
      ST_DONE
   } state_t;

   typedef enum logic {
      REQ_SAVE,
      REQ_LOAD
   } req_t;

   // States in which the watchdog accumulates waiting time.
   function automatic logic wd_counts(input state_t s);
      return (s == ST_PAUSE) || (s == ST_SAVE_RD) || (s == ST_LOAD_WR) || (s == ST_RESUME);
   endfunction

endpackage

// File: rtl/core_savestate_watchdog.sv
// Wait-time watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the count would reach TIMEOUT.
module savestate_watchdog #(
   parameter int unsigned TIMEOUT = 65535
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic expired_c
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

   logic [CW-1:0] count;
   logic [CW-1:0] count_eff;

   // A clear in the current cycle makes this the first counted cycle.
   assign count_eff = clear ? '0 : count;
   assign expired_c = en && (count_eff == LIMIT);

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= en ? CW'(1) : '0;
      end else if (en && (count != LIMIT)) begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/core_savestate_ctrl.sv
// Core-side savestate engine: pauses the core and copies state words between
// the core and the bridge-visible savestate buffer.
module core_savestate_ctrl
   import core_savestate_pkg::*;
#(
   parameter int unsigned SIZE_WORDS = 256,
   parameter int unsigned LOAD_WORDS = 256,
   parameter logic [31:0] BUF_ADDR   = 32'h4000_0000,
   parameter int unsigned TIMEOUT    = 65535,
   parameter int unsigned AW         = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          savestate_start,
   output logic          savestate_start_ack,
   output logic          savestate_start_busy,
   output logic          savestate_start_ok,
   output logic          savestate_start_err,
   input  logic          savestate_load,
   output logic          savestate_load_ack,
   output logic          savestate_load_busy,
   output logic          savestate_load_ok,
   output logic          savestate_load_err,
   output logic          savestate_supported,
   output logic [31:0]   savestate_addr,
   output logic [31:0]   savestate_size,
   output logic [31:0]   savestate_maxloadsize,
   output logic          core_pause_req,
   input  logic          core_paused,
   output logic [AW-1:0] st_addr,
   output logic          st_rd,
   output logic          st_wr,
   output logic [31:0]   st_wdata,
   input  logic [31:0]   st_rdata,
   input  logic          st_ack,
   output logic [AW-1:0] buf_addr,
   output logic          buf_wren,
   output logic [31:0]   buf_wdata,
   input  logic [31:0]   buf_q
);

   localparam int unsigned IW = AW + 1;
   localparam logic [IW-1:0] SAVE_LAST = IW'(SIZE_WORDS - 1);
   localparam logic [IW-1:0] LOAD_LAST = IW'(LOAD_WORDS - 1);

   state_t        state;
   state_t        prev_state;
   req_t          req_type;
   logic          start_arm;
   logic          load_arm;
   logic          fail;
   logic [IW-1:0] idx;
   logic          wd_expired;

   assign savestate_supported   = 1'b1;
   assign savestate_addr        = BUF_ADDR;
   assign savestate_size        = 32'(SIZE_WORDS * 4);
   assign savestate_maxloadsize = 32'(LOAD_WORDS * 4);

   savestate_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk       (clk),
      .reset     (reset),
      .clear     (state != prev_state),
      .en        (wd_counts(state)),
      .expired_c (wd_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state                <= ST_IDLE;
         prev_state           <= ST_IDLE;
         req_type             <= REQ_SAVE;
         start_arm            <= 1'b0;
         load_arm             <= 1'b0;
         fail                 <= 1'b0;
         idx                  <= '0;
         savestate_start_ack  <= 1'b0;
         savestate_start_busy <= 1'b0;
         savestate_start_ok   <= 1'b0;
         savestate_start_err  <= 1'b0;
         savestate_load_ack   <= 1'b0;
         savestate_load_busy  <= 1'b0;
         savestate_load_ok    <= 1'b0;
         savestate_load_err   <= 1'b0;
         core_pause_req       <= 1'b0;
         st_addr              <= '0;
         st_rd                <= 1'b0;
         st_wr                <= 1'b0;
         st_wdata             <= '0;
         buf_addr             <= '0;
         buf_wren             <= 1'b0;
         buf_wdata            <= '0;
      end else begin
         prev_state          <= state;
         savestate_start_ack <= 1'b0;
         savestate_load_ack  <= 1'b0;
         // A request must be seen low before it can be accepted again.
         if (!savestate_start) start_arm <= 1'b1;
         if (!savestate_load)  load_arm  <= 1'b1;
         if (savestate_start_ack) savestate_start_busy <= 1'b1;
         if (savestate_load_ack)  savestate_load_busy  <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (savestate_start && start_arm) begin
                  start_arm           <= 1'b0;
                  savestate_start_ack <= 1'b1;
                  savestate_start_ok  <= 1'b0;
                  savestate_start_err <= 1'b0;
                  req_type            <= REQ_SAVE;
                  core_pause_req      <= 1'b1;
                  fail                <= 1'b0;
                  idx                 <= '0;
                  state               <= ST_PAUSE;
               end else if (savestate_load && load_arm) begin
                  load_arm           <= 1'b0;
                  savestate_load_ack <= 1'b1;
                  savestate_load_ok  <= 1'b0;
                  savestate_load_err <= 1'b0;
                  req_type           <= REQ_LOAD;
                  core_pause_req     <= 1'b1;
                  fail               <= 1'b0;
                  idx                <= '0;
                  state              <= ST_PAUSE;
               end
            end
            ST_PAUSE: begin
               if (core_paused) begin
                  if (req_type == REQ_SAVE) begin
                     st_rd   <= 1'b1;
                     st_addr <= '0;
                     state   <= ST_SAVE_RD;
                  end else begin
                     buf_addr <= '0;
                     state    <= ST_LOAD_RA;
                  end
               end else if (wd_expired) begin
                  fail           <= 1'b1;
                  core_pause_req <= 1'b0;
                  state          <= ST_RESUME;
               end
            end
            ST_SAVE_RD: begin
               if (st_ack) begin
                  st_rd     <= 1'b0;
                  buf_wren  <= 1'b1;
                  buf_addr  <= AW'(idx);
                  buf_wdata <= st_rdata;
                  state     <= ST_SAVE_WR;
               end else if (wd_expired) begin
                  st_rd          <= 1'b0;
                  fail           <= 1'b1;
                  core_pause_req <= 1'b0;
                  state          <= ST_RESUME;
               end
            end
            ST_SAVE_WR: begin
               buf_wren <= 1'b0;
               idx      <= idx + IW'(1);
               if (idx < SAVE_LAST) begin
                  st_rd   <= 1'b1;
                  st_addr <= AW'(idx + IW'(1));
                  state   <= ST_SAVE_RD;
               end else begin
                  core_pause_req <= 1'b0;
                  state          <= ST_RESUME;
               end
            end
            ST_LOAD_RA: begin
               state <= ST_LOAD_RW;
            end
            ST_LOAD_RW: begin
               st_wdata <= buf_q;
               st_wr    <= 1'b1;
               st_addr  <= AW'(idx);
               state    <= ST_LOAD_WR;
            end
            ST_LOAD_WR: begin
               if (st_ack) begin
                  st_wr <= 1'b0;
                  idx   <= idx + IW'(1);
                  if (idx < LOAD_LAST) begin
                     buf_addr <= AW'(idx + IW'(1));
                     state    <= ST_LOAD_RA;
                  end else begin
                     core_pause_req <= 1'b0;
                     state          <= ST_RESUME;
                  end
               end else if (wd_expired) begin
                  st_wr          <= 1'b0;
                  fail           <= 1'b1;
                  core_pause_req <= 1'b0;
                  state          <= ST_RESUME;
               end
            end
            ST_RESUME: begin
               if (!core_paused) begin
                  state <= ST_DONE;
               end else if (wd_expired) begin
                  fail  <= 1'b1;
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               // busy falls in the same cycle the result flag rises.
               if (req_type == REQ_SAVE) begin
                  savestate_start_busy <= 1'b0;
                  savestate_start_ok   <= !fail;
                  savestate_start_err  <= fail;
               end else begin
                  savestate_load_busy <= 1'b0;
                  savestate_load_ok   <= !fail;
                  savestate_load_err  <= fail;
               end
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_core_savestate_ctrl.sv
// Directed bench for core_savestate_ctrl with small core, state-port and
// buffer BRAM responder models.
module tb_core_savestate_ctrl;

   logic        clk;
   logic        reset;
   logic        savestate_start;
   logic        savestate_start_ack, savestate_start_busy, savestate_start_ok, savestate_start_err;
   logic        savestate_load;
   logic        savestate_load_ack, savestate_load_busy, savestate_load_ok, savestate_load_err;
   logic        savestate_supported;
   logic [31:0] savestate_addr, savestate_size, savestate_maxloadsize;
   logic        core_pause_req;
   logic        core_paused;
   logic [3:0]  st_addr;
   logic        st_rd, st_wr;
   logic [31:0] st_wdata;
   logic [31:0] st_rdata;
   logic        st_ack;
   logic [3:0]  buf_addr;
   logic        buf_wren;
   logic [31:0] buf_wdata;
   logic [31:0] buf_q;

   int checks = 0;
   int errors = 0;

   // Responder state (written only by the responder process).
   logic [2:0]  pr_dly;
   logic        core_en;
   logic        do_preload;
   int          st_cnt;
   logic [31:0] bmem [16];
   logic [3:0]  addr_prev;
   logic [3:0]  wr_addr [64];
   logic [31:0] wr_data [64];
   int          wr_cnt, bw_cnt, rd_cycles, pr_cnt, sack_cnt, lack_cnt;

   core_savestate_ctrl #(
      .SIZE_WORDS (4),
      .LOAD_WORDS (4),
      .BUF_ADDR   (32'h4000_0000),
      .TIMEOUT    (16),
      .AW         (4)
   ) dut (
      .clk                   (clk),
      .reset                 (reset),
      .savestate_start       (savestate_start),
      .savestate_start_ack   (savestate_start_ack),
      .savestate_start_busy  (savestate_start_busy),
      .savestate_start_ok    (savestate_start_ok),
      .savestate_start_err   (savestate_start_err),
      .savestate_load        (savestate_load),
      .savestate_load_ack    (savestate_load_ack),
      .savestate_load_busy   (savestate_load_busy),
      .savestate_load_ok     (savestate_load_ok),
      .savestate_load_err    (savestate_load_err),
      .savestate_supported   (savestate_supported),
      .savestate_addr        (savestate_addr),
      .savestate_size        (savestate_size),
      .savestate_maxloadsize (savestate_maxloadsize),
      .core_pause_req        (core_pause_req),
      .core_paused           (core_paused),
      .st_addr               (st_addr),
      .st_rd                 (st_rd),
      .st_wr                 (st_wr),
      .st_wdata              (st_wdata),
      .st_rdata              (st_rdata),
      .st_ack                (st_ack),
      .buf_addr              (buf_addr),
      .buf_wren              (buf_wren),
      .buf_wdata             (buf_wdata),
      .buf_q                 (buf_q)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Core, state port and buffer models, all updated on the falling edge.
   initial begin
      pr_dly = '0; core_paused = 1'b0; st_cnt = 0; st_ack = 1'b0; st_rdata = '0;
      buf_q = '0; addr_prev = '0; wr_cnt = 0; bw_cnt = 0; rd_cycles = 0;
      pr_cnt = 0; sack_cnt = 0; lack_cnt = 0;
      for (int i = 0; i < 16; i++) bmem[i] = '0;
      forever begin
         @(negedge clk);
         pr_dly      = {pr_dly[1:0], core_pause_req};
         core_paused = core_en & pr_dly[2];
         if (st_ack) begin
            st_ack = 1'b0;
         end else if (st_rd || st_wr) begin
            st_cnt++;
            if (st_cnt == 2) begin
               st_cnt   = 0;
               st_ack   = 1'b1;
               st_rdata = 32'h1111_1111 * (32'(st_addr) + 32'd1);
               if (st_wr) begin
                  wr_addr[wr_cnt % 64] = st_addr;
                  wr_data[wr_cnt % 64] = st_wdata;
                  wr_cnt++;
               end
            end
         end else begin
            st_cnt = 0;
         end
         if (st_rd) rd_cycles++;
         if (core_pause_req) pr_cnt++;
         if (savestate_start_ack) sack_cnt++;
         if (savestate_load_ack) lack_cnt++;
         if (do_preload) for (int i = 0; i < 4; i++) bmem[i] = 32'h0000_00A0 + 32'(i);
         if (buf_wren) begin
            bmem[buf_addr] = buf_wdata;
            bw_cnt++;
         end
         buf_q     = bmem[addr_prev];
         addr_prev = buf_addr;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_save_done(input string tag);
      int n = 0;
      while (!savestate_start_ok && !savestate_start_err && n < 300) begin tick(); n++; end
      check(tag, 32'(n < 300), 32'd1);
   endtask

   task automatic wait_load_done(input string tag);
      int n = 0;
      while (!savestate_load_ok && !savestate_load_err && n < 300) begin tick(); n++; end
      check(tag, 32'(n < 300), 32'd1);
   endtask

   int sack0, lack0, bw0, wr0, rd0, pr0, n;

   initial begin
      reset = 1'b1; savestate_start = 1'b1; savestate_load = 1'b0;
      core_en = 1'b1; do_preload = 1'b0;
      repeat (4) tick();

      // Reset values and descriptor constants.
      check("rst_ack", 32'(savestate_start_ack), 0);
      check("rst_busy", 32'(savestate_start_busy), 0);
      check("rst_ok", 32'(savestate_start_ok), 0);
      check("rst_pause", 32'(core_pause_req), 0);
      check("rst_strobes", 32'({st_rd, st_wr, buf_wren}), 0);
      check("supported", 32'(savestate_supported), 1);
      check("addr", savestate_addr, 32'h4000_0000);
      check("size", savestate_size, 32'd16);
      check("maxload", savestate_maxloadsize, 32'd16);

      // Request already high at reset release is ignored.
      sack0 = sack_cnt;
      reset = 1'b0;
      repeat (10) tick();
      check("noarm_ack", 32'(sack_cnt - sack0), 0);
      check("noarm_pause", 32'(core_pause_req), 0);
      savestate_start = 1'b0;
      tick();

      // Normal save.
      sack0 = sack_cnt; bw0 = bw_cnt;
      savestate_start = 1'b1;
      tick();
      check("save_ack", 32'(savestate_start_ack), 1);
      check("save_pause", 32'(core_pause_req), 1);
      check("save_busy_n1", 32'(savestate_start_busy), 0);
      tick();
      check("save_ack_low", 32'(savestate_start_ack), 0);
      check("save_busy_n2", 32'(savestate_start_busy), 1);
      wait_save_done("save_done");
      check("save_ok", 32'(savestate_start_ok), 1);
      check("save_err", 32'(savestate_start_err), 0);
      check("save_busy_end", 32'(savestate_start_busy), 0);
      check("save_pause_end", 32'(core_pause_req), 0);
      check("save_bw", 32'(bw_cnt - bw0), 4);
      for (int i = 0; i < 4; i++) check("save_buf", bmem[i], 32'h1111_1111 * 32'(i + 1));

      // Held request never retriggers.
      repeat (100) tick();
      check("hold_ack", 32'(sack_cnt - sack0), 1);
      check("hold_ok", 32'(savestate_start_ok), 1);

      // Toggle starts a fresh save, clearing ok first.
      savestate_start = 1'b0;
      tick();
      savestate_start = 1'b1;
      tick();
      check("resave_ack", 32'(savestate_start_ack), 1);
      check("resave_ok_clr", 32'(savestate_start_ok), 0);
      wait_save_done("resave_done");
      check("resave_ok", 32'(savestate_start_ok), 1);
      savestate_start = 1'b0;
      tick();

      // Load from a preloaded buffer.
      do_preload = 1'b1;
      tick();
      do_preload = 1'b0;
      tick();
      wr0 = wr_cnt; bw0 = bw_cnt;
      savestate_load = 1'b1;
      tick();
      check("load_ack", 32'(savestate_load_ack), 1);
      wait_load_done("load_done");
      check("load_ok", 32'(savestate_load_ok), 1);
      check("load_err", 32'(savestate_load_err), 0);
      check("load_busy_end", 32'(savestate_load_busy), 0);
      check("load_wr_cnt", 32'(wr_cnt - wr0), 4);
      check("load_no_bufwr", 32'(bw_cnt - bw0), 0);
      for (int k = 0; k < 4; k++) begin
         check("load_st_addr", 32'(wr_addr[wr0 + k]), 32'(k));
         check("load_st_data", wr_data[wr0 + k], 32'h0000_00A0 + 32'(k));
      end
      check("load_save_ok", 32'(savestate_start_ok), 1);
      check("load_save_err", 32'(savestate_start_err), 0);
      savestate_load = 1'b0;
      tick();

      // Simultaneous requests: save first, then load.
      lack0 = lack_cnt;
      savestate_start = 1'b1; savestate_load = 1'b1;
      tick();
      check("sim_save_ack", 32'(savestate_start_ack), 1);
      check("sim_load_ack0", 32'(savestate_load_ack), 0);
      wait_save_done("sim_save_done");
      check("sim_save_ok", 32'(savestate_start_ok), 1);
      check("sim_load_wait", 32'(lack_cnt - lack0), 0);
      tick();
      check("sim_load_ack", 32'(savestate_load_ack), 1);
      check("sim_load_ok_clr", 32'(savestate_load_ok), 0);
      wait_load_done("sim_load_done");
      check("sim_load_ok", 32'(savestate_load_ok), 1);
      savestate_start = 1'b0; savestate_load = 1'b0;
      tick();

      // Pause timeout: core never halts.
      core_en = 1'b0;
      tick();
      rd0 = rd_cycles; pr0 = pr_cnt;
      savestate_start = 1'b1;
      tick();
      wait_save_done("to_done");
      check("to_err", 32'(savestate_start_err), 1);
      check("to_ok", 32'(savestate_start_ok), 0);
      check("to_no_rd", 32'(rd_cycles - rd0), 0);
      check("to_pause_cycles", 32'(pr_cnt - pr0), 16);
      check("to_pause_drop", 32'(core_pause_req), 0);
      check("to_busy", 32'(savestate_start_busy), 0);
      savestate_start = 1'b0;
      core_en = 1'b1;
      repeat (5) tick();

      // Reset while reading state word 2.
      savestate_start = 1'b1;
      n = 0;
      while (!(st_rd && st_addr == 4'd2) && n < 200) begin tick(); n++; end
      check("mid_reach", 32'(n < 200), 1);
      reset = 1'b1;
      tick();
      check("mid_pause", 32'(core_pause_req), 0);
      check("mid_ok_err_busy", 32'({savestate_start_ok, savestate_start_err, savestate_start_busy}), 0);
      check("mid_st_rd", 32'(st_rd), 0);
      reset = 1'b0;
      savestate_start = 1'b0;
      repeat (6) tick();
      sack0 = sack_cnt; bw0 = bw_cnt;
      savestate_start = 1'b1;
      tick();
      check("post_ack", 32'(savestate_start_ack), 1);
      wait_save_done("post_done");
      check("post_ok", 32'(savestate_start_ok), 1);
      check("post_bw", 32'(bw_cnt - bw0), 4);
      check("post_buf3", bmem[3], 32'h4444_4444);
      savestate_start = 1'b0;
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
